// File: rtl/square_wave_pkg.sv
// Shared constants for the square-wave generator and its detector: state encoding and reset defaults.
// Loopback limits line up only if the generator and the detector both take their defaults from here.
package square_wave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int SWG_CNT_W    = 16;
   localparam int SWG_DEF_HIGH = 50;
   localparam int SWG_DEF_LOW  = 50;

endpackage

// File: rtl/swg_cfg_shadow.sv
// Pending/active high-low configuration with a zero check and a boundary bypass; oCfgErr is registered one cycle after a bad strobe.
// The config that governs a new period is combinational, so it can be used on the same apply edge; loads are never stalled.
module swg_cfg_shadow
   import square_wave_pkg::*;
#(
   parameter int CNT_W    = SWG_CNT_W,
   parameter int DEF_HIGH = SWG_DEF_HIGH,
   parameter int DEF_LOW  = SWG_DEF_LOW
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iLoad,
   input  logic [CNT_W-1:0] iHighCnt,
   input  logic [CNT_W-1:0] iLowCnt,
   input  logic             iApply,
   output logic [CNT_W-1:0] oEffHigh,
   output logic [CNT_W-1:0] oActLow,
   output logic             oCfgErr
);

   typedef struct packed {
      logic [CNT_W-1:0] high;
      logic [CNT_W-1:0] low;
   } cfg_t;

   cfg_t active, pending, reqCfg, effCfg;
   logic pendVld;
   logic loadOk;

   assign reqCfg.high = iHighCnt;
   assign reqCfg.low  = iLowCnt;
   assign loadOk      = iLoad && (iHighCnt != '0) && (iLowCnt != '0);

   // A good load on the apply edge wins over anything already pending.
   assign effCfg   = loadOk ? reqCfg : (pendVld ? pending : active);
   assign oEffHigh = effCfg.high;
   assign oActLow  = active.low;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         active.high <= CNT_W'(DEF_HIGH);
         active.low  <= CNT_W'(DEF_LOW);
         pending     <= '0;
         pendVld     <= 1'b0;
         oCfgErr     <= 1'b0;
      end else begin
         oCfgErr <= iLoad && !loadOk;
         if (iApply) begin
            active  <= effCfg;
            pendVld <= 1'b0;
         end else if (loadOk) begin
            pending <= reqCfg;
            pendVld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator, whole periods only; output rises on the edge that samples iEnable high in IDLE.
// No backpressure: iEnable is checked only at period boundaries, and iLoad is accepted on any cycle.
module square_wave_gen
   import square_wave_pkg::*;
#(
   parameter int CNT_W    = SWG_CNT_W,
   parameter int DEF_HIGH = SWG_DEF_HIGH,
   parameter int DEF_LOW  = SWG_DEF_LOW
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iEnable,
   input  logic             iLoad,
   input  logic [CNT_W-1:0] iHighCnt,
   input  logic [CNT_W-1:0] iLowCnt,
   output logic             oSquareWave,
   output logic             oPeriodDone,
   output logic             oBusy,
   output logic             oCfgErr
);

   state_t           state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [CNT_W-1:0] effHigh, actLow;
   logic             apply;

   swg_cfg_shadow #(
      .CNT_W   (CNT_W),
      .DEF_HIGH(DEF_HIGH),
      .DEF_LOW (DEF_LOW)
   ) uCfgShadow (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iLoad   (iLoad),
      .iHighCnt(iHighCnt),
      .iLowCnt (iLowCnt),
      .iApply  (apply),
      .oEffHigh(effHigh),
      .oActLow (actLow),
      .oCfgErr (oCfgErr)
   );

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      apply     = 1'b0;
      case (state)
         IDLE: begin
            if (iEnable) begin
               stateNext = HIGH;
               apply     = 1'b1;
               cntNext   = effHigh - CNT_W'(1);
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               stateNext = LOW;
               cntNext   = actLow - CNT_W'(1);
            end else begin
               cntNext = cnt - CNT_W'(1);
            end
         end
         LOW: begin
            if (cnt != '0) begin
               cntNext = cnt - CNT_W'(1);
            end else if (iEnable) begin
               stateNext = HIGH;
               apply     = 1'b1;
               cntNext   = effHigh - CNT_W'(1);
            end else begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         oSquareWave <= 1'b0;
         oPeriodDone <= 1'b0;
         oBusy       <= 1'b0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         oSquareWave <= (stateNext == HIGH);
         oPeriodDone <= (stateNext == LOW) && (cntNext == '0);
         oBusy       <= (stateNext != IDLE);
      end
   end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed test of square_wave_gen: defaults, reconfiguration, boundary bypass, rejected load, graceful stop, async reset.
module tb_square_wave_gen;

   logic        iClk;
   logic        iRst_n;
   logic        iEnable;
   logic        iLoad;
   logic [15:0] iHighCnt;
   logic [15:0] iLowCnt;
   logic        oSquareWave;
   logic        oPeriodDone;
   logic        oBusy;
   logic        oCfgErr;

   int checks   = 0;
   int failures = 0;

   square_wave_gen dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iEnable    (iEnable),
      .iLoad      (iLoad),
      .iHighCnt   (iHighCnt),
      .iLowCnt    (iLowCnt),
      .oSquareWave(oSquareWave),
      .oPeriodDone(oPeriodDone),
      .oBusy      (oBusy),
      .oCfgErr    (oCfgErr)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Measures one phase starting at the current sample; stops when the level changes or the generator idles.
   task automatic phase(input string tag, input logic lvl, input int expLen);
      int len, pdCnt, pdPos;
      len = 0; pdCnt = 0; pdPos = 0;
      while (oSquareWave === lvl && oBusy === 1'b1 && len < 1000) begin
         len++;
         if (oPeriodDone === 1'b1) begin
            pdCnt++;
            pdPos = len;
         end
         tick();
      end
      chk({tag, ".len"}, len, expLen);
      chk({tag, ".pdCnt"}, pdCnt, lvl ? 0 : 1);
      chk({tag, ".pdPos"}, pdPos, lvl ? 0 : expLen);
   endtask

   task automatic load(input logic [15:0] h, input logic [15:0] l);
      iLoad = 1'b1; iHighCnt = h; iLowCnt = l;
      tick();
      iLoad = 1'b0; iHighCnt = '0; iLowCnt = '0;
   endtask

   initial begin
      iRst_n = 1'b0; iEnable = 1'b0; iLoad = 1'b0; iHighCnt = '0; iLowCnt = '0;
      repeat (3) tick();
      chk("rst.wave", oSquareWave, 1'b0);
      chk("rst.busy", oBusy, 1'b0);
      chk("rst.pd", oPeriodDone, 1'b0);
      chk("rst.err", oCfgErr, 1'b0);

      // Default 50/50 wave, output high on the first edge that sees iEnable.
      iRst_n = 1'b1; iEnable = 1'b1;
      tick();
      chk("start.wave", oSquareWave, 1'b1);
      chk("start.busy", oBusy, 1'b1);
      phase("def1.hi", 1'b1, 50);
      phase("def1.lo", 1'b0, 50);

      // Load 3/5 in the middle of HIGH: current period unchanged, next one is 3/5.
      repeat (9) tick();
      load(16'd3, 16'd5);
      phase("recfg.hiRest", 1'b1, 40);
      phase("recfg.lo", 1'b0, 50);
      phase("cfg35a.hi", 1'b1, 3);
      phase("cfg35a.lo", 1'b0, 5);

      // Load 2/2 in the last LOW cycle: bypass governs the very next period.
      repeat (7) tick();
      chk("bypass.lastLowPd", oPeriodDone, 1'b1);
      load(16'd2, 16'd2);
      phase("bypass.hi", 1'b1, 2);
      phase("bypass.lo", 1'b0, 2);

      // Load 6/3 one cycle before the last LOW cycle: goes through pending.
      repeat (2) tick();
      load(16'd6, 16'd3);
      tick();
      phase("early.hi", 1'b1, 6);
      phase("early.lo", 1'b0, 3);

      // Zero high count is rejected with a one-cycle error pulse.
      load(16'd0, 16'd7);
      chk("rej.errPulse", oCfgErr, 1'b1);
      tick();
      chk("rej.errClear", oCfgErr, 1'b0);
      phase("rej.hiRest", 1'b1, 4);
      phase("rej.lo", 1'b0, 3);
      phase("rej.nextHi", 1'b1, 6);
      phase("rej.nextLo", 1'b0, 3);

      // Graceful stop: switch to 12/4, then drop iEnable at HIGH cycle 10.
      load(16'd12, 16'd4);
      phase("pre.hiRest", 1'b1, 5);
      phase("pre.lo", 1'b0, 3);
      repeat (9) tick();
      iEnable = 1'b0;
      tick();
      phase("stop.hiRest", 1'b1, 2);
      phase("stop.lo", 1'b0, 4);
      chk("idle.wave", oSquareWave, 1'b0);
      chk("idle.busy", oBusy, 1'b0);
      repeat (3) tick();
      chk("idle.stay", oBusy, 1'b0);
      iEnable = 1'b1;
      tick();
      chk("restart.wave", oSquareWave, 1'b1);
      phase("restart.hi", 1'b1, 12);

      // Async reset mid-LOW with a pending 3/3 load.
      load(16'd3, 16'd3);
      #2;
      iRst_n = 1'b0;
      #1;
      chk("arst.wave", oSquareWave, 1'b0);
      chk("arst.busy", oBusy, 1'b0);
      chk("arst.pd", oPeriodDone, 1'b0);
      tick();
      iRst_n = 1'b1;
      tick();
      phase("post.hi", 1'b1, 50);
      phase("post.lo", 1'b0, 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
